// File: rtl/bsg_gateway_nbf_streamer.sv
// Gateway-side NBF loader: turns write records into single-beat I/O write commands,
// tracks in-flight commands against a credit limit, and implements fence/finish records.
module bsg_gateway_nbf_streamer #(
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 64,
  parameter int max_outstanding_p = 16,
  localparam int lg_outstanding_lp = $clog2(max_outstanding_p + 1),
  localparam int nbf_width_lp      = 8 + paddr_width_p + data_width_p
) (
  input  logic                         blackparrot_clk,
  input  logic                         blackparrot_reset,
  input  logic [nbf_width_lp-1:0]      nbf_i,
  input  logic                         nbf_v_i,
  output logic                         nbf_ready_o,
  output logic [paddr_width_p-1:0]     io_cmd_addr_o,
  output logic [data_width_p-1:0]      io_cmd_data_o,
  output logic [1:0]                   io_cmd_size_o,
  output logic                         io_cmd_v_o,
  input  logic                         io_cmd_ready_i,
  input  logic                         io_resp_v_i,
  output logic                         io_resp_yumi_o,
  output logic [lg_outstanding_lp-1:0] outstanding_o,
  output logic                         done_o,
  output logic                         error_o
);

  typedef enum logic [2:0] {
    READY  = 3'd0,
    SEND   = 3'd1,
    FENCE  = 3'd2,
    FINISH = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [7:0] op_write4_lp = 8'h02;
  localparam logic [7:0] op_write8_lp = 8'h03;
  localparam logic [7:0] op_fence_lp  = 8'hFE;
  localparam logic [7:0] op_finish_lp = 8'hFF;

  state_e                         state_q;
  logic [paddr_width_p-1:0]       addr_q;
  logic [data_width_p-1:0]        data_q;
  logic [1:0]                     size_q;
  logic [lg_outstanding_lp-1:0]   count_q, count_d;
  logic                           error_q, error_d;

  logic [7:0]                     rec_op;
  logic [paddr_width_p-1:0]       rec_addr;
  logic [data_width_p-1:0]        rec_data;
  logic                           nbf_fire, cmd_fire, resp_fire;

  assign {rec_op, rec_addr, rec_data} = nbf_i;

  // Ready and yumi are gated by the raw reset so both read 0 the moment reset asserts.
  assign nbf_ready_o    = blackparrot_reset & (state_q == READY)
                        & (count_q < lg_outstanding_lp'(max_outstanding_p));
  assign io_resp_yumi_o = blackparrot_reset & io_resp_v_i;

  assign nbf_fire  = nbf_v_i & nbf_ready_o;
  assign cmd_fire  = (state_q == SEND) & io_cmd_ready_i;
  assign resp_fire = io_resp_yumi_o;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    error_d = error_q;
    if (cmd_fire && !resp_fire) begin
      count_d = count_q + 1'b1;
    end else if (resp_fire && !cmd_fire) begin
      if (count_q == '0) error_d = 1'b1;
      else               count_d = count_q - 1'b1;
    end
    if (nbf_fire && !(rec_op inside {op_write4_lp, op_write8_lp, op_fence_lp, op_finish_lp}))
      error_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      state_q <= READY;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      error_q <= error_d;
      unique case (state_q)
        READY: if (nbf_fire) begin
          unique case (rec_op)
            op_write4_lp, op_write8_lp: begin
              addr_q  <= rec_addr;
              data_q  <= rec_data;
              size_q  <= (rec_op == op_write4_lp) ? 2'd2 : 2'd3;
              state_q <= SEND;
            end
            op_fence_lp:  state_q <= FENCE;
            op_finish_lp: state_q <= FINISH;
            default:      state_q <= READY;
          endcase
        end
        SEND:   if (io_cmd_ready_i)  state_q <= READY;
        FENCE:  if (count_q == '0)   state_q <= READY;
        FINISH: if (count_q == '0)   state_q <= DONE;
        DONE:                        state_q <= DONE;
        default:                     state_q <= READY;
      endcase
    end
  end

  assign io_cmd_v_o    = (state_q == SEND);
  assign io_cmd_addr_o = addr_q;
  assign io_cmd_data_o = data_q;
  assign io_cmd_size_o = size_q;
  assign outstanding_o = count_q;
  assign done_o        = (state_q == DONE);
  assign error_o       = error_q;

endmodule

// File: tb/tb_bsg_gateway_nbf_streamer.sv
// Directed bench for bsg_gateway_nbf_streamer: expected commands go into a scoreboard
// queue at record acceptance and a monitor compares them at each command handshake.
module tb_bsg_gateway_nbf_streamer;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int RW = 8 + AW + DW;
  localparam int LW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    size;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] nbf_i;
  logic          nbf_v_i;
  logic          nbf_ready_o;
  logic [AW-1:0] io_cmd_addr_o;
  logic [DW-1:0] io_cmd_data_o;
  logic [1:0]    io_cmd_size_o;
  logic          io_cmd_v_o;
  logic          io_cmd_ready_i;
  logic          io_resp_v_i;
  logic          io_resp_yumi_o;
  logic [LW-1:0] outstanding_o;
  logic          done_o;
  logic          error_o;

  cmd_t exp_q[$];
  cmd_t mon_got, mon_exp;
  int   checks = 0;
  int   errors = 0;
  int   resp_cnt;

  always #5 clk = ~clk;

  bsg_gateway_nbf_streamer dut (
    .blackparrot_clk   (clk),
    .blackparrot_reset (rst_n),
    .nbf_i             (nbf_i),
    .nbf_v_i           (nbf_v_i),
    .nbf_ready_o       (nbf_ready_o),
    .io_cmd_addr_o     (io_cmd_addr_o),
    .io_cmd_data_o     (io_cmd_data_o),
    .io_cmd_size_o     (io_cmd_size_o),
    .io_cmd_v_o        (io_cmd_v_o),
    .io_cmd_ready_i    (io_cmd_ready_i),
    .io_resp_v_i       (io_resp_v_i),
    .io_resp_yumi_o    (io_resp_yumi_o),
    .outstanding_o     (outstanding_o),
    .done_o            (done_o),
    .error_o           (error_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every command handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && io_cmd_v_o && io_cmd_ready_i) begin
      mon_got = '{addr: io_cmd_addr_o, data: io_cmd_data_o, size: io_cmd_size_o};
      if (exp_q.size() == 0) begin
        check("cmd_unexpected", 128'(mon_got), 128'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("cmd", 128'(mon_got), 128'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one record and returns #1 after the edge on which it was accepted.
  task automatic send_rec(input logic [7:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    nbf_i   = {op, a, d};
    nbf_v_i = 1'b1;
    while (!nbf_ready_o && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      check("record_accept_timeout", 128'(0), 128'(1));
    end else begin
      @(posedge clk);
      if (op == 8'h02 || op == 8'h03)
        exp_q.push_back('{addr: a, data: d, size: (op == 8'h02) ? 2'd2 : 2'd3});
      #1;
    end
    nbf_v_i = 1'b0;
  endtask

  task automatic pulse_resp();
    io_resp_v_i = 1'b1;
    #1;
    check("resp_yumi", 128'(io_resp_yumi_o), 128'(1));
    @(posedge clk);
    #1;
    io_resp_v_i = 1'b0;
    resp_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    io_resp_v_i = 1'b1;
    #1;
    check("rst_cmd_v",   128'(io_cmd_v_o),     128'(0));
    check("rst_ready",   128'(nbf_ready_o),    128'(0));
    check("rst_yumi",    128'(io_resp_yumi_o), 128'(0));
    check("rst_count",   128'(outstanding_o),  128'(0));
    check("rst_done",    128'(done_o),         128'(0));
    check("rst_error",   128'(error_o),        128'(0));
    check("rst_addr",    128'(io_cmd_addr_o),  128'(0));
    io_resp_v_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    #1;
  endtask

  initial begin
    nbf_i = '0; nbf_v_i = 1'b0; io_cmd_ready_i = 1'b1; io_resp_v_i = 1'b0; resp_cnt = 0;
    rst_n = 1'b0;
    #3;
    do_reset();
    check("ready_after_reset", 128'(nbf_ready_o), 128'(1));

    // Single 8B write with a response one cycle after the command.
    send_rec(8'h03, 40'h80000000, 64'hDEADBEEF_CAFEF00D);
    check("w8_cmd_v",    128'(io_cmd_v_o),    128'(1));
    check("w8_count_0",  128'(outstanding_o), 128'(0));
    check("w8_busy",     128'(nbf_ready_o),   128'(0));
    step();
    check("w8_count_1",  128'(outstanding_o), 128'(1));
    check("w8_cmd_idle", 128'(io_cmd_v_o),    128'(0));
    pulse_resp();
    check("w8_count_end", 128'(outstanding_o), 128'(0));
    check("w8_error",     128'(error_o),       128'(0));

    // Back-pressure on a 4B write: command must hold still.
    io_cmd_ready_i = 1'b0;
    send_rec(8'h02, 40'h00_0000_1000, 64'h11223344_55667788);
    for (int i = 0; i < 5; i++) begin
      check("bp_v",     128'(io_cmd_v_o),    128'(1));
      check("bp_addr",  128'(io_cmd_addr_o), 128'(40'h1000));
      check("bp_data",  128'(io_cmd_data_o), 128'(64'h11223344_55667788));
      check("bp_ready", 128'(nbf_ready_o),   128'(0));
      step();
    end
    io_cmd_ready_i = 1'b1;
    step();
    check("bp_count", 128'(outstanding_o), 128'(1));
    pulse_resp();

    // Credit limit: 16 writes without responses.
    for (int i = 0; i < 16; i++)
      send_rec(8'h03, 40'h10_0000_0000 + 40'(i * 8), {32'(i), ~32'(i)});
    step();
    check("cred_count_16", 128'(outstanding_o), 128'(16));
    check("cred_stall",    128'(nbf_ready_o),   128'(0));
    pulse_resp();
    check("cred_count_15", 128'(outstanding_o), 128'(15));
    check("cred_reopen",   128'(nbf_ready_o),   128'(1));
    send_rec(8'h02, 40'h20_0000_0000, 64'h0000_0017_0000_0017);
    // Command handshake and response in the same cycle leave the count alone.
    io_resp_v_i = 1'b1;
    step();
    io_resp_v_i = 1'b0;
    check("cred_simul", 128'(outstanding_o), 128'(15));
    for (int i = 0; i < 15; i++) pulse_resp();
    check("cred_drained", 128'(outstanding_o), 128'(0));
    check("cred_error",   128'(error_o),       128'(0));

    // Fence with nothing outstanding returns to READY on the next cycle.
    send_rec(8'hFE, '0, '0);
    check("fence0_busy",  128'(nbf_ready_o), 128'(0));
    step();
    check("fence0_ready", 128'(nbf_ready_o), 128'(1));

    // Fence behind three writes whose responses arrive 50 cycles later.
    resp_cnt = 0;
    fork
      begin
        repeat (50) step();
        for (int i = 0; i < 3; i++) pulse_resp();
      end
    join_none
    for (int i = 0; i < 3; i++)
      send_rec(8'h03, 40'h30_0000_0000 + 40'(i), 64'hF0F0_0000_0000_0000 + 64'(i));
    send_rec(8'hFE, '0, '0);
    send_rec(8'h03, 40'h30_0000_0100, 64'hABCD_0000_0000_0005);
    check("fence_resps_before_5th", 128'(resp_cnt),      128'(3));
    check("fence_count_at_5th",     128'(outstanding_o), 128'(0));
    step();
    pulse_resp();
    check("fence_drained", 128'(outstanding_o), 128'(0));

    // Finish behind two writes.
    send_rec(8'h03, 40'h40_0000_0000, 64'h1);
    send_rec(8'h02, 40'h40_0000_0008, 64'h2);
    send_rec(8'hFF, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check("fin_not_done", 128'(done_o),      128'(0));
      check("fin_stall",    128'(nbf_ready_o), 128'(0));
      step();
    end
    pulse_resp();
    check("fin_not_done_1", 128'(done_o), 128'(0));
    pulse_resp();
    check("fin_not_done_0", 128'(done_o), 128'(0));
    step();
    check("fin_done", 128'(done_o), 128'(1));
    nbf_i = {8'h03, 40'h50_0000_0000, 64'h9};
    nbf_v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("done_ignores_ready", 128'(nbf_ready_o), 128'(0));
      check("done_no_cmd",        128'(io_cmd_v_o),  128'(0));
      check("done_sticky",        128'(done_o),      128'(1));
      step();
    end
    nbf_v_i = 1'b0;
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    // Illegal opcode: dropped, error set, back to READY.
    do_reset();
    send_rec(8'h55, 40'h1, 64'h2);
    check("illegal_error", 128'(error_o),     128'(1));
    check("illegal_ready", 128'(nbf_ready_o), 128'(1));
    check("illegal_no_cmd", 128'(io_cmd_v_o), 128'(0));

    // Spurious response with nothing outstanding.
    do_reset();
    pulse_resp();
    check("spurious_error", 128'(error_o),       128'(1));
    check("spurious_count", 128'(outstanding_o), 128'(0));

    // Reset asserted while a command is stuck in SEND.
    do_reset();
    io_cmd_ready_i = 1'b0;
    send_rec(8'h03, 40'h60_0000_0000, 64'h77);
    step();
    check("midsend_v", 128'(io_cmd_v_o), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midsend_rst_v",     128'(io_cmd_v_o),  128'(0));
    check("midsend_rst_ready", 128'(nbf_ready_o), 128'(0));
    io_cmd_ready_i = 1'b1;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    check("midsend_ready", 128'(nbf_ready_o),   128'(1));
    check("midsend_count", 128'(outstanding_o), 128'(0));
    step();
    check("midsend_idle",  128'(io_cmd_v_o),    128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
